// File: rtl/key_event_gen.sv
// Per-button press/release/long-press/auto-repeat event generator.
// Auto-repeat pulses are built only when KEY_EVENT_REPEAT_EN is defined.
module key_event_gen #(
    parameter int N_BTN         = 5,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic [N_BTN-1:0] held
);

    localparam int MAXC = (LONG_CYCLES > REPEAT_CYCLES) ?
                          LONG_CYCLES : REPEAT_CYCLES;
    localparam int CW = (MAXC > 2) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;
`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } state_t;

    state_t            state_q [N_BTN];
    logic [CW-1:0]     cnt_q   [N_BTN];
    logic [N_BTN-1:0]  press_q;
    logic [N_BTN-1:0]  release_q;
    logic [N_BTN-1:0]  long_q;
    logic [N_BTN-1:0]  held_q;
`ifdef KEY_EVENT_REPEAT_EN
    logic [N_BTN-1:0]  repeat_q;
`endif

    // cnt_q is 0 on the first cycle after an event, so it reaches
    // N-1 exactly N clocks after that event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            held_q    <= '0;
`ifdef KEY_EVENT_REPEAT_EN
            repeat_q  <= '0;
`endif
        end else begin
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
`ifdef KEY_EVENT_REPEAT_EN
            repeat_q  <= '0;
`endif
            for (int i = 0; i < N_BTN; i++) begin
                unique case (state_q[i])
                    IDLE: begin
                        if (btn_level[i]) begin
                            state_q[i] <= PRESS;
                            cnt_q[i]   <= '0;
                            press_q[i] <= 1'b1;
                        end
                    end
                    PRESS: begin
                        if (!btn_level[i]) begin
                            state_q[i]   <= IDLE;
                            cnt_q[i]     <= '0;
                            release_q[i] <= 1'b1;
                        end else if (cnt_q[i] == LONG_LAST) begin
                            state_q[i] <= LONG;
                            cnt_q[i]   <= '0;
                            long_q[i]  <= 1'b1;
                            held_q[i]  <= 1'b1;
                        end else if (cnt_q[i] != CNT_MAX) begin
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
                    end
                    LONG: begin
                        if (!btn_level[i]) begin
                            state_q[i]   <= IDLE;
                            cnt_q[i]     <= '0;
                            release_q[i] <= 1'b1;
                            held_q[i]    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
                        end else if (cnt_q[i] == REP_LAST) begin
                            cnt_q[i]    <= '0;
                            repeat_q[i] <= 1'b1;
                        end else if (cnt_q[i] != CNT_MAX) begin
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
`else
                        end else begin
                            cnt_q[i] <= '0;
                        end
`endif
                    end
                    default: begin
                        state_q[i] <= IDLE;
                        cnt_q[i]   <= '0;
                        held_q[i]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign held          = held_q;
`ifdef KEY_EVENT_REPEAT_EN
    assign repeat_pulse  = repeat_q;
`else
    assign repeat_pulse  = '0;
`endif

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Repeat expectations follow KEY_EVENT_REPEAT_EN as defined for the build.
module tb_key_event_gen;

`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [4:0] btn_level;
    logic [4:0] press_pulse;
    logic [4:0] release_pulse;
    logic [4:0] long_pulse;
    logic [4:0] repeat_pulse;
    logic [4:0] held;

    int n_cmp = 0;
    int n_bad = 0;

    key_event_gen #(
        .N_BTN        (5),
        .LONG_CYCLES  (8),
        .REPEAT_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] obs,
                       input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] p,
                           input logic [4:0] r, input logic [4:0] l,
                           input logic [4:0] rp, input logic [4:0] h);
        chk({tag, ".press"},   press_pulse,   p);
        chk({tag, ".release"}, release_pulse, r);
        chk({tag, ".long"},    long_pulse,    l);
        chk({tag, ".repeat"},  repeat_pulse,  rp);
        chk({tag, ".held"},    held,          h);
    endtask

    // advance one active edge and sample just after it
    task automatic step(input string tag, input logic [4:0] p,
                        input logic [4:0] r, input logic [4:0] l,
                        input logic [4:0] rp, input logic [4:0] h);
        @(posedge clk);
        #1;
        chk_all(tag, p, r, l, rp, h);
    endtask

    initial begin
        logic [4:0] ep, er, el, erp, eh;

        rst_n     = 1'b0;
        btn_level = 5'h00;
        #2;
        chk_all("reset", 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("idle", 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);

        // short press on btn0: high for 3 sampled edges
        btn_level = 5'h01;
        step("short0", 5'h01, 5'h00, 5'h00, 5'h00, 5'h00);
        step("short1", 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        step("short2", 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        btn_level = 5'h00;
        step("short3", 5'h00, 5'h01, 5'h00, 5'h00, 5'h00);
        step("short4", 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);

        // long press on btn2: high 20 edges, release on a due repeat
        for (int k = 0; k <= 20; k++) begin
            btn_level = (k < 20) ? 5'h04 : 5'h00;
            ep  = (k == 0)  ? 5'h04 : 5'h00;
            er  = (k == 20) ? 5'h04 : 5'h00;
            el  = (k == 8)  ? 5'h04 : 5'h00;
            erp = (REP_EN && (k == 12 || k == 16)) ? 5'h04 : 5'h00;
            eh  = (k >= 8 && k < 20) ? 5'h04 : 5'h00;
            step($sformatf("long[%0d]", k), ep, er, el, erp, eh);
        end
        step("long_after", 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);

        // btn1 released exactly on the long threshold edge
        for (int k = 0; k <= 8; k++) begin
            btn_level = (k < 8) ? 5'h02 : 5'h00;
            ep = (k == 0) ? 5'h02 : 5'h00;
            er = (k == 8) ? 5'h02 : 5'h00;
            step($sformatf("bound[%0d]", k), ep, er, 5'h00, 5'h00, 5'h00);
        end
        step("bound_after", 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);

        // btn3 then btn4 two cycles later, overlapping holds
        for (int k = 0; k <= 13; k++) begin
            if (k >= 13)     btn_level = 5'h00;
            else if (k >= 2) btn_level = 5'h18;
            else             btn_level = 5'h08;
            ep  = (k == 0) ? 5'h08 : ((k == 2) ? 5'h10 : 5'h00);
            er  = (k == 13) ? 5'h18 : 5'h00;
            el  = (k == 8) ? 5'h08 : ((k == 10) ? 5'h10 : 5'h00);
            erp = (REP_EN && k == 12) ? 5'h08 : 5'h00;
            eh  = 5'h00;
            if (k >= 8 && k < 13)  eh[3] = 1'b1;
            if (k >= 10 && k < 13) eh[4] = 1'b1;
            step($sformatf("conc[%0d]", k), ep, er, el, erp, eh);
        end

        // single-cycle glitch on btn0
        btn_level = 5'h01;
        step("glitch0", 5'h01, 5'h00, 5'h00, 5'h00, 5'h00);
        btn_level = 5'h00;
        step("glitch1", 5'h00, 5'h01, 5'h00, 5'h00, 5'h00);

        // all buttons held into long, then async reset mid-hold
        btn_level = 5'h1F;
        for (int k = 0; k <= 9; k++) begin
            ep  = (k == 0) ? 5'h1F : 5'h00;
            el  = (k == 8) ? 5'h1F : 5'h00;
            eh  = (k >= 8) ? 5'h1F : 5'h00;
            step($sformatf("all[%0d]", k), ep, 5'h00, el, 5'h00, eh);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("midrst", 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        @(posedge clk);
        #1;
        chk_all("inrst", 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        rst_n = 1'b1;
        step("rstrel0", 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00);
        step("rstrel1", 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        btn_level = 5'h00;
        step("rstrel2", 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00);
        step("final", 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
